// File: rtl/vit_pkg.sv
// Trellis parameters and parity helper shared by the convolutional encoder and
// the Viterbi decoder, so both ends of the link agree on the code.
package vit_pkg;

    localparam int K = 4;
    localparam logic [K-1:0] G0 = 4'b1111;
    localparam logic [K-1:0] G1 = 4'b1101;
    localparam int TCW = (K > 2) ? $clog2(K - 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } enc_state_t;

    // Window is {newest bit, sr}; bit 0 of the result is the G0 parity.
    function automatic logic [1:0] conv_pair(logic [K-1:0] w);
        return {^(w & G1), ^(w & G0)};
    endfunction

endpackage

// File: rtl/conv_enc_r12.sv
// Rate-1/2 convolutional encoder with zero-tail termination and a single
// output register on a valid/ready stream.
//
// state | meaning
// IDLE  | no frame open, sr == 0, waiting for the first info bit
// DATA  | frame open, encoding accepted info bits
// TAIL  | input closed, flushing K-1 zero bits back to state 0
module conv_enc_r12
    import vit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_pair,
    output logic       out_last,
    output logic       busy
);

    enc_state_t     state;
    logic [K-2:0]   sr;
    logic [TCW-1:0] tail_cnt;
    logic           load;
    logic           accept;
    logic           tail_done;
    logic [K-1:0]   w;

    assign load      = !out_valid || out_ready;
    // rst_n gating keeps in_ready low while reset is held.
    assign in_ready  = rst_n && load && (state != TAIL);
    assign accept    = in_valid && in_ready;
    assign tail_done = (tail_cnt == TCW'(K - 2));
    assign w         = (state == TAIL) ? {1'b0, sr} : {in_bit, sr};
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sr        <= '0;
            tail_cnt  <= '0;
            out_valid <= 1'b0;
            out_pair  <= 2'b00;
            out_last  <= 1'b0;
        end else if (load) begin
            if (state == TAIL) begin
                out_valid <= 1'b1;
                out_pair  <= conv_pair(w);
                out_last  <= tail_done;
                sr        <= w[K-1:1];
                if (tail_done) begin
                    state    <= IDLE;
                    tail_cnt <= '0;
                end else begin
                    tail_cnt <= tail_cnt + TCW'(1);
                end
            end else if (accept) begin
                out_valid <= 1'b1;
                out_pair  <= conv_pair(w);
                out_last  <= 1'b0;
                sr        <= w[K-1:1];
                tail_cnt  <= '0;
                state     <= in_last ? TAIL : DATA;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_enc_r12.sv
// Self-checking bench for conv_enc_r12: directed vector table, mid-frame reset,
// and a randomized multi-frame run against a tap-sum reference and bit recovery.
module tb_conv_enc_r12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic       out_last;
    logic       busy;
    logic [1:0] out_pair;

    int errors = 0;
    int checks = 0;

    localparam logic [3:0] GEN0 = 4'o17;
    localparam logic [3:0] GEN1 = 4'o15;
    localparam int NFRAMES = 1000;

    always #5 clk = ~clk;

    conv_enc_r12 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pair  (out_pair),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pair i of a frame: tap j multiplies the bit j steps back, zero outside the frame.
    function automatic logic [1:0] ref_pair(input logic [15:0] bits, input int len, input int i);
        logic p0, p1, b;
        int   idx;
        p0 = 1'b0;
        p1 = 1'b0;
        for (int j = 0; j < 4; j++) begin
            idx = i - j;
            b   = (idx >= 0 && idx < len) ? bits[idx] : 1'b0;
            p0  = p0 ^ (GEN0[3-j] & b);
            p1  = p1 ^ (GEN1[3-j] & b);
        end
        return {p1, p0};
    endfunction

    typedef struct {
        logic [7:0]  bits;    // bit i is the i-th info bit driven
        logic [7:0]  lasts;   // in_last flag per info bit
        int          nbits;
        logic [19:0] pairs;   // pair i at [2i+:2]
        logic [9:0]  plast;   // expected out_last per pair
        int          npairs;
        bit          stall;   // out_ready follows 1,0,0,1 pattern
        int          gap_lo;  // expected in_ready-low cycles mid-stream, -1 = unchecked
    } vec_t;

    vec_t vecs[4];

    task automatic run_vec(input vec_t v, input string tag);
        int         idx, got, cyc, gap;
        logic       held, prev_last;
        logic [1:0] prev_pair;
        logic [3:0] pat;
        pat  = 4'b1001;
        idx  = 0;
        got  = 0;
        cyc  = 0;
        gap  = 0;
        held = 1'b0;
        prev_pair = 2'b00;
        prev_last = 1'b0;
        while (got < v.npairs && cyc < 200) begin
            @(negedge clk);
            out_ready = v.stall ? pat[cyc % 4] : 1'b1;
            in_valid  = (idx < v.nbits);
            in_bit    = v.bits[idx % 8];
            in_last   = v.lasts[idx % 8];
            #1;
            if (held) begin
                chk({tag, "_hold_pair"}, 32'(out_pair), 32'(prev_pair));
                chk({tag, "_hold_last"}, 32'(out_last), 32'(prev_last));
            end
            held = out_valid && !out_ready;
            if (held) chk({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
            prev_pair = out_pair;
            prev_last = out_last;
            if (in_valid && !in_ready && idx > 0 && idx < v.nbits) gap++;
            if (out_valid && out_ready) begin
                chk({tag, "_pair"}, 32'(out_pair), 32'(v.pairs[2*got +: 2]));
                chk({tag, "_last"}, 32'(out_last), 32'(v.plast[got]));
                if (out_last) chk({tag, "_busy_after_last"}, 32'(busy), 32'd0);
                got++;
            end
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({tag, "_pair_count"}, 32'(got), 32'(v.npairs));
        if (v.gap_lo >= 0) chk({tag, "_tail_gap"}, 32'(gap), 32'(v.gap_lo));
        repeat (2) @(negedge clk);
    endtask

    typedef struct packed { logic b; logic l; } src_t;
    typedef struct packed { logic [1:0] p; logic l; } exp_t;

    initial begin
        src_t        src_q[$];
        exp_t        exp_q[$];
        logic [15:0] fr_bits[$];
        int          fr_len[$];
        int          got, fidx, pos, nlast, cyc, len;
        logic [15:0] bits, dec;
        logic [2:0]  hist;
        logic        d, held, prev_last;
        logic [1:0]  prev_pair;
        exp_t        e;

        // Frame 1,0,1,1: pairs 11,11,10,11,10,10,11 (listed last-pair first below)
        vecs[0] = '{bits: 8'b0000_1101, lasts: 8'b0000_1000, nbits: 4,
                    pairs: 20'b00_00_00_11_10_10_11_10_11_11, plast: 10'b00_0100_0000,
                    npairs: 7, stall: 1'b0, gap_lo: 0};
        // Single-bit frame: 11,11,01,11
        vecs[1] = '{bits: 8'b0000_0001, lasts: 8'b0000_0001, nbits: 1,
                    pairs: 20'b00_00_00_00_00_00_11_01_11_11, plast: 10'b00_0000_1000,
                    npairs: 4, stall: 1'b0, gap_lo: 0};
        vecs[2] = vecs[0];
        vecs[2].stall  = 1'b1;
        vecs[2].gap_lo = -1;
        // Frames 1,1 then 0,1: 11,00,10,10,11 then 00,11,11,01,11
        vecs[3] = '{bits: 8'b0000_1011, lasts: 8'b0000_1010, nbits: 4,
                    pairs: 20'b11_01_11_11_00_11_10_10_00_11, plast: 10'b10_0001_0000,
                    npairs: 10, stall: 1'b0, gap_lo: 3};

        // Reset state
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pair", 32'(out_pair), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset during a frame, after the 2nd pair has been seen
        got = 0;
        pos = 0;
        cyc = 0;
        while (got < 2 && cyc < 50) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (pos < 4);
            in_bit    = vecs[0].bits[pos % 8];
            in_last   = vecs[0].lasts[pos % 8];
            #1;
            if (out_valid && out_ready) got++;
            if (in_valid && in_ready) pos++;
            cyc++;
        end
        chk("midrst_reach", 32'(got), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_pair", 32'(out_pair), 32'd0);
        chk("midrst_out_last", 32'(out_last), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[0], "after_rst");

        // Randomized frames with random valid gaps and backpressure
        for (int f = 0; f < NFRAMES; f++) begin
            len  = int'($urandom_range(1, 12));
            bits = 16'($urandom) & 16'((1 << len) - 1);
            fr_bits.push_back(bits);
            fr_len.push_back(len);
            for (int i = 0; i < len; i++) src_q.push_back('{b: bits[i], l: (i == len - 1)});
            for (int i = 0; i < len + 3; i++)
                exp_q.push_back('{p: ref_pair(bits, len, i), l: (i == len + 2)});
        end
        fidx  = 0;
        pos   = 0;
        nlast = 0;
        cyc   = 0;
        hist  = 3'b000;
        dec   = '0;
        held  = 1'b0;
        prev_pair = 2'b00;
        prev_last = 1'b0;
        while (exp_q.size() > 0 && cyc < 60000) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            if (src_q.size() > 0 && $urandom_range(0, 4) != 0) begin
                in_valid = 1'b1;
                in_bit   = src_q[0].b;
                in_last  = src_q[0].l;
            end else begin
                in_valid = 1'b0;
                in_bit   = 1'($urandom);
                in_last  = 1'($urandom);
            end
            #1;
            if (held) begin
                chk("rnd_hold_pair", 32'(out_pair), 32'(prev_pair));
                chk("rnd_hold_last", 32'(out_last), 32'(prev_last));
            end
            held = out_valid && !out_ready;
            if (held) chk("rnd_stall_in_ready", 32'(in_ready), 32'd0);
            prev_pair = out_pair;
            prev_last = out_last;
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                chk("rnd_pair", 32'(out_pair), 32'(e.p));
                chk("rnd_last", 32'(out_last), 32'(e.l));
                chk("rnd_busy", 32'(busy), 32'(!out_last));
                // G0 taps every window bit, so the info bit is recoverable from pair[0].
                d    = out_pair[0] ^ hist[0] ^ hist[1] ^ hist[2];
                hist = {hist[1:0], d};
                if (pos < 16) dec[pos] = d;
                pos++;
                if (out_last) begin
                    nlast++;
                    if (fidx < fr_bits.size())
                        chk("rnd_decoded_frame", 32'(dec & 16'((1 << fr_len[fidx]) - 1)),
                            32'(fr_bits[fidx]));
                    fidx++;
                    pos  = 0;
                    hist = 3'b000;
                    dec  = '0;
                end
            end
            if (in_valid && in_ready) void'(src_q.pop_front());
            cyc++;
        end
        in_valid = 1'b0;
        chk("rnd_pairs_left", 32'(exp_q.size()), 32'd0);
        chk("rnd_frame_count", 32'(nlast), 32'(NFRAMES));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
